// File: rtl/bp_lce_cmd_buffer_if.sv
// Handshake bundle around the LCE command buffer.
// Network side uses ready->valid; LCE side uses valid->yumi.
// The buffer takes the slave modport; whoever feeds the network
// messages and plays the LCE takes the master modport.
interface bp_lce_cmd_buffer_if
  #(parameter int els_p       = 2
  , parameter int msg_width_p = 8
  );

    localparam int count_width_lp = $clog2(els_p + 1);

    logic [msg_width_p-1:0]    lce_cmd_i;
    logic                      lce_cmd_v_i;
    logic                      lce_cmd_ready_o;
    logic [msg_width_p-1:0]    lce_cmd_o;
    logic                      lce_cmd_v_o;
    logic                      lce_cmd_yumi_i;
    logic [count_width_lp-1:0] count_o;
    logic [count_width_lp-1:0] high_water_o;

    modport slave (
        input  lce_cmd_i, lce_cmd_v_i, lce_cmd_yumi_i,
        output lce_cmd_ready_o, lce_cmd_o, lce_cmd_v_o, count_o, high_water_o
    );

    modport master (
        output lce_cmd_i, lce_cmd_v_i, lce_cmd_yumi_i,
        input  lce_cmd_ready_o, lce_cmd_o, lce_cmd_v_o, count_o, high_water_o
    );

endinterface

// File: rtl/bp_lce_cmd_buffer.sv
// Elastic buffer on the inbound CCE-to-LCE command path.
// Circular store of els_p messages with occupancy and high-water reporting.
// Optional feature macro: BP_LCE_CMD_BUFFER_BYPASS_EN -- when defined, an
// empty buffer forwards the incoming message to the LCE in the same cycle.
// The io interface instance must be built with the same els_p/msg_width_p.
module bp_lce_cmd_buffer
  #(parameter int bp_params_p = 0
  , parameter int els_p       = 2
  , parameter int msg_width_p = 8
  )
  (input  logic                   clk_i
  , input logic                   reset_i
  , bp_lce_cmd_buffer_if.slave    io
  );

    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int count_width_lp = $clog2(els_p + 1);
    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

    // Pointer wrap relies on a power-of-two depth, so reject anything else.
    if (bp_params_p < 0 || els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_cfg
        $error("bp_lce_cmd_buffer: els_p must be a power of two >= 2");
    end

    logic [msg_width_p-1:0]    mem [els_p];
    logic [ptr_width_lp-1:0]   rptr_r, wptr_r;
    logic [count_width_lp-1:0] count_r, count_next, high_water_r;
    logic                      empty, full, enq, deq, bypass_take;

    assign empty = (count_r == '0);
    assign full  = (count_r == full_count_lp);

    // Ready comes only from registered state so the network never sees yumi.
    assign io.lce_cmd_ready_o = ~full;

`ifdef BP_LCE_CMD_BUFFER_BYPASS_EN
    // A message consumed in the same cycle it arrives never touches storage.
    assign bypass_take    = empty & io.lce_cmd_v_i & io.lce_cmd_yumi_i;
    assign io.lce_cmd_v_o = ~empty | io.lce_cmd_v_i;
    assign io.lce_cmd_o   = empty ? io.lce_cmd_i : mem[rptr_r];
`else
    assign bypass_take    = 1'b0;
    assign io.lce_cmd_v_o = ~empty;
    assign io.lce_cmd_o   = mem[rptr_r];
`endif

    // A yumi against an empty store is either a bypass or illegal; both leave state alone.
    assign enq = io.lce_cmd_v_i & ~full & ~bypass_take;
    assign deq = io.lce_cmd_yumi_i & ~empty;

    assign count_next = count_r + count_width_lp'(enq) - count_width_lp'(deq);

    assign io.count_o      = count_r;
    assign io.high_water_o = high_water_r;

    // Message storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr_r] <= io.lce_cmd_i;
        end
    end

    // Pointers, occupancy and high-water mark; high water saturates because count cannot exceed els_p.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r       <= '0;
            wptr_r       <= '0;
            count_r      <= '0;
            high_water_r <= '0;
        end else begin
            if (enq) begin
                wptr_r <= wptr_r + ptr_width_lp'(1);
            end
            if (deq) begin
                rptr_r <= rptr_r + ptr_width_lp'(1);
            end
            count_r <= count_next;
            if (count_next > high_water_r) begin
                high_water_r <= count_next;
            end
        end
    end

    // The LCE must only consume a message that is being presented.
    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) io.lce_cmd_yumi_i |-> io.lce_cmd_v_o
    );

endmodule
